demux_event_counter: RTL
========================

// Module: demux_event_counter
// PURPOSE
//  Downstream consumer of the 1-to-4 demultiplexer. Samples the 4 demux output lines.
//  Counts rising edges per channel in saturating counters.
//  Reports per-channel overflow and exposes counts through a registered read port.
//  Sits between the demux and the status/readout logic.
// PARAMETERS
//  CNT_W        8   counter width per channel (2..16)
//  SYNC_STAGES  2   input synchronizer depth, 0 (inputs already in clk domain) or 2
//  RD_CLEAR     0   1: a read clears the addressed counter and its overflow flag
// PORTS
//  clk        in   1      single clock, rising-edge
//  rst        in   1      asynchronous, active-high reset
//  demux_out  in   4      demux output lines, bit i = channel i
//  clr        in   1      synchronous clear of all counters and overflow flags
//  rd_en      in   1      read request, sampled on clk
//  rd_sel     in   2      channel to read
//  rd_data    out  CNT_W  count of channel rd_sel, registered
//  rd_valid   out  1      1-cycle pulse, rd_data valid
//  ovf        out  4      sticky saturation flag per channel
//  active     out  4      registered copy of synchronized demux_out (level)
// BEHAVIOUR
//  Reset (rst=1, async):
//   - all counters, ovf, active, rd_data, rd_valid and sync/edge registers = 0.
//  Input path:
//   - demux_out passes SYNC_STAGES flops, then a 1-flop edge history (prev).
//   - rise[i] = sync[i] & ~prev[i].
//   - A line already high when rst deasserts counts as one edge.
//  Counting:
//   - On rise[i], cnt[i] <= cnt[i]+1.
//   - At cnt[i] = 2^CNT_W-1, a further rise holds the value and sets ovf[i].
//   - Channels are independent; any number of lines may rise in the same cycle.
//  Latency:
//   - An edge on demux_out updates cnt SYNC_STAGES+1 cycles later.
//   - active follows the same delay as sync, not as cnt.
//  Read:
//   - rd_en=1 in cycle N -> in cycle N+1: rd_data = cnt[rd_sel] as held in cycle N, rd_valid=1.
//   - Otherwise rd_valid=0 and rd_data holds its last value.
//   - Back-to-back reads are allowed, one per cycle.
//  RD_CLEAR=1:
//   - The addressed counter and its ovf clear at the end of the read cycle.
//   - A rise in the same cycle as the read: the read returns the pre-increment value, the counter becomes 1.
//  clr:
//   - All cnt = 0 and ovf = 0 next cycle; prev/sync are not cleared.
//   - A rise in the same cycle as clr is lost (clr wins).
//   - A read in the same cycle as clr returns the pre-clear value.
//  Priority per channel: clr > read-clear > increment.
//   - The read-clear + increment case is the exception: the result is 1.
//  rst mid-read: rd_valid drops to 0 immediately; nothing else is preserved.
// STRUCTURE
//  demux_pkg (shared): NUM_CH=4, SEL_W=2; localparam CNT_MAX derived from CNT_W.
//  Sub-module demux_edge_counter, one per channel (generate loop over NUM_CH):
//   - inputs: sync bit, clr, rd_clr.
//   - outputs: cnt, ovf.
//  Top level holds the synchronizers, the read mux and the rd_data/rd_valid registers.
// TESTING
//  1. Reset: rst=1 with demux_out=4'hF -> all outputs 0. Release -> each cnt=1 after SYNC_STAGES+1 cycles.
//  2. Pulse channel 2 five times (2-cycle high, 2-cycle low), then read sel=2 -> rd_data=5, rd_valid 1 cycle.
//     Channels 0, 1 and 3 read 0.
//  3. CNT_W=4: 20 edges on channel 1 -> rd_data=15, ovf=4'b0010. Then clr -> reads 0, ovf=0.
//  4. RD_CLEAR=1: 3 edges on channel 0; read, with a rise in the read cycle -> rd_data=3. Next read -> 1.
//  5. Simultaneous: demux_out 0->4'hF together with clr -> no count. Next rising edge counts from 0.
//  6. Assert rst during an active count and read -> immediate zero; counting resumes normally after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the demux event counter slice.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Saturation value of an unsigned counter of width w.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/demux_event_counter_if.sv
// Bus between the demux/readout side and the event counter.
interface demux_event_counter_if #(
  parameter int CNT_W = 8
) ();
  import demux_pkg::*;

  logic [NUM_CH-1:0] demux_out;
  logic              clr;
  logic              rd_en;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] active;

  modport master (
    output demux_out, clr, rd_en, rd_sel,
    input  rd_data, rd_valid, ovf, active
  );

  modport slave (
    input  demux_out, clr, rd_en, rd_sel,
    output rd_data, rd_valid, ovf, active
  );

endinterface

// File: rtl/demux_edge_counter.sv
// One channel: edge history, saturating rising-edge counter and sticky overflow.
module demux_edge_counter
  import demux_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rise;

  // Next state: clr beats read-clear beats increment; read-clear with a rise yields 1.
  always_comb begin
    rise   = sync_in & ~prev_q;
    prev_d = sync_in;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (rd_clr) begin
      cnt_d = rise ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (rise) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; prev resets low so a line high at reset release counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/demux_event_counter.sv
// Counts rising edges on the four demux lines and serves counts through a registered read port.
module demux_event_counter
  import demux_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_CLEAR    = 0
) (
  input  logic              clk,
  input  logic              rst,
  demux_event_counter_if.slave bus
);

  logic [NUM_CH-1:0] sync_w;
  logic [NUM_CH-1:0] active_w;
  logic [NUM_CH-1:0] rd_clr_w;
  logic [NUM_CH-1:0] ovf_w;
  logic [CNT_W-1:0]  cnt_w [NUM_CH];

  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  if (SYNC_STAGES == 2) begin : g_sync2
    logic [NUM_CH-1:0] s1_q, s1_d, s2_q, s2_d;

    // Two-flop synchronizer; the last stage doubles as the active level.
    always_comb begin
      s1_d = bus.demux_out;
      s2_d = s1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q <= '0;
        s2_q <= '0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
    end

    assign sync_w   = s2_q;
    assign active_w = s2_q;
  end else begin : g_sync0
    logic [NUM_CH-1:0] active_q, active_d;

    // Inputs are already clk-domain; only active needs a register.
    always_comb active_d = bus.demux_out;

    // Active level register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) active_q <= '0;
      else     active_q <= active_d;
    end

    assign sync_w   = bus.demux_out;
    assign active_w = active_q;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign rd_clr_w[i] = (RD_CLEAR != 0) && bus.rd_en && (bus.rd_sel == SEL_W'(i));

    demux_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .sync_in(sync_w[i]),
      .clr    (bus.clr),
      .rd_clr (rd_clr_w[i]),
      .cnt    (cnt_w[i]),
      .ovf    (ovf_w[i])
    );
  end

  // Read port: capture the selected count as held this cycle; data holds between reads.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.rd_en;
    if (bus.rd_en) rd_data_d = cnt_w[bus.rd_sel];
  end

  // Read port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ovf      = ovf_w;
  assign bus.active   = active_w;

endmodule
